// File: rtl/imem_loader.sv
// Boot-time instruction ROM loader.
// Receives a framed byte stream (16-bit length, big-endian words, XOR checksum),
// writes each word into the ROM write port and holds the core in reset until
// a complete frame passes its checksum.
module imem_loader #(
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              o_wr,
    output logic [AWIDTH-1:0] o_waddr,
    output logic [DWIDTH-1:0] o_wdata,
    output logic              o_core_rst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [AWIDTH:0]   o_nwords
);

    // Largest legal word count: the whole address space.
    localparam logic [16:0] MaxLen = 17'(2 ** AWIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e              state_q, state_d;
    logic                s_ready_q, s_ready_d;
    logic                wr_q, wr_d;
    logic [AWIDTH-1:0]   waddr_q, waddr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic                core_rst_q, core_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [AWIDTH:0]     nwords_q, nwords_d;
    logic [7:0]          acc_q, acc_d;
    logic [7:0]          byte_q, byte_d;
    logic [AWIDTH:0]     len_q, len_d;

    logic                accept;
    logic [16:0]         len_full;
    logic [AWIDTH:0]     nwords_inc;

    assign accept     = s_valid && s_ready_q;
    // Header word count, zero-extended so it can be compared against 2^AWIDTH.
    assign len_full   = {1'b0, byte_q, s_data};
    assign nwords_inc = nwords_q + {{AWIDTH{1'b0}}, 1'b1};

    // Next-state and registered-output logic for the frame parser.
    always_comb begin
        state_d    = state_q;
        wr_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        core_rst_d = core_rst_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        nwords_d   = nwords_q;
        acc_d      = acc_q;
        byte_d     = byte_q;
        len_d      = len_q;

        // Every accepted byte, checksum included, folds into the accumulator.
        if (accept) begin
            acc_d = acc_q ^ s_data;
        end

        case (state_q)
            StIdle, StDone, StErr: begin
                if (i_start) begin
                    state_d    = StLenHi;
                    core_rst_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    nwords_d   = '0;
                    acc_d      = '0;
                    waddr_d    = '0;
                end
            end
            StLenHi: begin
                if (accept) begin
                    byte_d  = s_data;
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    if (len_full == '0) begin
                        state_d = StCsum;
                    end else if (len_full > MaxLen) begin
                        // Program cannot fit: abort without consuming more bytes.
                        state_d = StErr;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        len_d   = len_full[AWIDTH:0];
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (accept) begin
                    byte_d  = s_data;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    // Words written so far double as the write index.
                    wr_d     = 1'b1;
                    waddr_d  = nwords_q[AWIDTH-1:0];
                    wdata_d  = DWIDTH'({byte_q, s_data});
                    nwords_d = nwords_inc;
                    state_d  = (nwords_inc == len_q) ? StCsum : StDataHi;
                end
            end
            StCsum: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if ((acc_q ^ s_data) == 8'h00) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        // Core stays in reset; partial ROM contents are left as-is.
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Ready is registered, so derive it from where the FSM is heading.
        s_ready_d = (state_d == StLenHi) || (state_d == StLenLo) ||
                    (state_d == StDataHi) || (state_d == StDataLo) ||
                    (state_d == StCsum);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            s_ready_q  <= 1'b0;
            wr_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            nwords_q   <= '0;
            acc_q      <= '0;
            byte_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            wr_q       <= wr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            nwords_q   <= nwords_d;
            acc_q      <= acc_d;
            byte_q     <= byte_d;
            len_q      <= len_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign o_wr       = wr_q;
    assign o_waddr    = waddr_q;
    assign o_wdata    = wdata_q;
    assign o_core_rst = core_rst_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_nwords   = nwords_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a frame-level model predicts ROM writes and
// final load status; a monitor compares them as the DUT produces them.
module tb_imem_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct packed {
        logic        done;
        logic        err;
        logic        core_rst;
        logic [AW:0] nwords;
    } st_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          o_wr;
    logic [AW-1:0] o_waddr;
    logic [DW-1:0] o_wdata;
    logic          o_core_rst;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [AW:0]   o_nwords;

    imem_loader #(
        .AWIDTH(AW),
        .DWIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .o_wr       (o_wr),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .o_core_rst (o_core_rst),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_nwords   (o_nwords)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_wq[$];
    st_t exp_sq[$];
    logic busy_prev = 1'b0;
    wr_t mon_w;
    st_t mon_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: derive writes and outcome straight from the frame bytes.
    task automatic expect_frame(input bq_t fr);
        int         n;
        logic [7:0] x;
        wr_t        w;
        st_t        s;
        n = int'({fr[0], fr[1]});
        if (n > (1 << AW)) begin
            s.done = 1'b0; s.err = 1'b1; s.core_rst = 1'b1; s.nwords = '0;
            exp_sq.push_back(s);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w.addr = AW'(i);
            w.data = {fr[2 + 2 * i], fr[3 + 2 * i]};
            exp_wq.push_back(w);
        end
        x = 8'h00;
        foreach (fr[k]) x ^= fr[k];
        s.done     = (x == 8'h00);
        s.err      = (x != 8'h00);
        s.core_rst = (x != 8'h00);
        s.nwords   = (AW + 1)'(n);
        exp_sq.push_back(s);
    endtask

    function automatic bq_t rand_frame(input int n, input bit corrupt);
        bq_t        f;
        logic [7:0] c;
        f.push_back(8'(n >> 8));
        f.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) f.push_back(8'($urandom));
        c = 8'h00;
        foreach (f[k]) c ^= f[k];
        if (corrupt) c ^= 8'($urandom_range(1, 255));
        f.push_back(c);
        return f;
    endfunction

    // Monitor: pops expected writes on o_wr and expected status when busy drops.
    always @(negedge clk) begin
        if (o_wr === 1'b1) begin
            if (exp_wq.size() == 0) begin
                check("unexpected_wr", 32'(o_waddr), 32'hffff_ffff);
            end else begin
                mon_w = exp_wq.pop_front();
                check("wr_addr", 32'(o_waddr), 32'(mon_w.addr));
                check("wr_data", 32'(o_wdata), 32'(mon_w.data));
                check("wr_nwords", 32'(o_nwords), 32'(mon_w.addr) + 1);
            end
        end
        if (busy_prev === 1'b1 && o_busy === 1'b0) begin
            if (exp_sq.size() == 0) begin
                check("unexpected_end", 32'(o_done), 32'hffff_ffff);
            end else begin
                mon_s = exp_sq.pop_front();
                check("st_done", 32'(o_done), 32'(mon_s.done));
                check("st_err", 32'(o_err), 32'(mon_s.err));
                check("st_core_rst", 32'(o_core_rst), 32'(mon_s.core_rst));
                check("st_nwords", 32'(o_nwords), 32'(mon_s.nwords));
                check("st_s_ready", 32'(s_ready), 32'd0);
            end
        end
        busy_prev = o_busy;
    end

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // gap: 0 = always valid, 1 = alternating, 2 = random.
    // start_at: byte index at which to inject a stray i_start (-1 for none).
    task automatic send(input bq_t fr, input int gap, input int start_at);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit acc;
        bit started = 1'b0;
        while (idx < fr.size() && cyc < 4000) begin
            @(negedge clk);
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_data  = fr[idx];
            i_start = (idx == start_at) && !started;
            if (i_start) started = 1'b1;
            acc = v && s_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        i_start = 1'b0;
        check("bytes_accepted", 32'(idx), 32'(fr.size()));
    endtask

    task automatic wait_idle();
        int c = 0;
        while (o_busy !== 1'b0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("busy_cleared", 32'(o_busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_wr"}, 32'(o_wr), 32'd0);
        check({tag, "_waddr"}, 32'(o_waddr), 32'd0);
        check({tag, "_wdata"}, 32'(o_wdata), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_err"}, 32'(o_err), 32'd0);
        check({tag, "_nwords"}, 32'(o_nwords), 32'd0);
        check({tag, "_core_rst"}, 32'(o_core_rst), 32'd1);
    endtask

    task automatic load(input bq_t fr, input int gap, input int start_at);
        expect_frame(fr);
        pulse_start();
        send(fr, gap, start_at);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t  happy;
        bq_t  fr;
        wr_t  w;
        st_t  s;
        happy = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h42};

        rst = 1'b1; i_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // Happy path, then restart from DONE must re-assert core reset at once.
        load(happy, 0, -1);
        check("happy_core_rst", 32'(o_core_rst), 32'd0);
        expect_frame(happy);
        pulse_start();
        check("restart_core_rst", 32'(o_core_rst), 32'd1);
        check("restart_done", 32'(o_done), 32'd0);
        check("restart_busy", 32'(o_busy), 32'd1);
        send(happy, 0, -1);
        wait_idle();

        // Zero length.
        fr = '{8'h00, 8'h00, 8'h00};
        load(fr, 0, -1);

        // Bad checksum.
        fr = happy;
        fr[8] = 8'h43;
        load(fr, 0, -1);
        check("badcsum_core_rst", 32'(o_core_rst), 32'd1);

        // Over-length header.
        fr = '{8'h01, 8'h01};
        load(fr, 0, -1);
        check("overlen_s_ready", 32'(s_ready), 32'd0);

        // Alternating valid gaps, and a stray start mid-load.
        load(happy, 1, -1);
        load(happy, 0, 5);

        // Reset after four bytes: one word already written, then reset values.
        w.addr = '0; w.data = 16'h1234;
        exp_wq.push_back(w);
        s.done = 1'b0; s.err = 1'b0; s.core_rst = 1'b1; s.nwords = '0;
        exp_sq.push_back(s);
        pulse_start();
        fr = '{8'h00, 8'h03, 8'h12, 8'h34};
        send(fr, 0, -1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        load(happy, 0, -1);

        // Largest legal program fills the whole address space.
        load(rand_frame(1 << AW, 1'b0), 0, -1);

        // Randomised frames with random gaps and occasional corruption.
        for (int t = 0; t < 10; t++) begin
            load(rand_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0)), 2, -1);
        end

        check("wq_empty", 32'(exp_wq.size()), 32'd0);
        check("sq_empty", 32'(exp_sq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
